// File: rtl/alu_issue_if.sv
// Handshake and payload bundle between the decode/issue stage and its neighbours.
// The slave modport is the issue stage; the master modport is the surrounding pipeline.
interface alu_issue_if;
  logic        i_valid;
  logic        o_in_ready;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic        i_flush;
  logic        o_valid;
  logic        i_out_ready;
  logic [2:0]  o_opsel;
  logic        o_sub;
  logic        o_unsigned;
  logic        o_arith;
  logic [31:0] o_op1;
  logic [31:0] o_op2;
  logic [31:0] o_rs2_data;
  logic        o_branch;
  logic [2:0]  o_br_funct3;
  logic        o_jump;
  logic        o_load;
  logic        o_store;
  logic [4:0]  o_rd;
  logic        o_rd_wen;
  logic        o_illegal;

  modport slave (
    input  i_valid, i_inst, i_pc, i_rs1_data, i_rs2_data, i_flush, i_out_ready,
    output o_in_ready, o_valid, o_opsel, o_sub, o_unsigned, o_arith, o_op1, o_op2,
           o_rs2_data, o_branch, o_br_funct3, o_jump, o_load, o_store, o_rd,
           o_rd_wen, o_illegal
  );

  modport master (
    output i_valid, i_inst, i_pc, i_rs1_data, i_rs2_data, i_flush, i_out_ready,
    input  o_in_ready, o_valid, o_opsel, o_sub, o_unsigned, o_arith, o_op1, o_op2,
           o_rs2_data, o_branch, o_br_funct3, o_jump, o_load, o_store, o_rd,
           o_rd_wen, o_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: decodes one instruction into ALU controls and operands
// and holds them in a single-entry valid/ready register slice.
module alu_issue #(
  parameter bit ZERO_RD_WEN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  alu_issue_if.slave  bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [2:0]  opsel;
    logic        sub;
    logic        uns;
    logic        arith;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        branch;
    logic [2:0]  br_funct3;
    logic        jump;
    logic        load;
    logic        store;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        illegal;
  } ctrl_t;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] rs2_q;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [4:0]  rd_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_u_s;
  logic        legal_s;
  logic        writes_s;
  logic        in_ready_s;
  logic        accept_s;

  // Instruction field extraction and sign-extended immediates
  always_comb begin
    opcode_s = bus.i_inst[6:0];
    funct3_s = bus.i_inst[14:12];
    funct7_s = bus.i_inst[31:25];
    rd_s     = bus.i_inst[11:7];
    imm_i_s  = {{20{bus.i_inst[31]}}, bus.i_inst[31:20]};
    imm_s_s  = {{20{bus.i_inst[31]}}, bus.i_inst[31:25], bus.i_inst[11:7]};
    imm_u_s  = {bus.i_inst[31:12], 12'h000};
  end

  // Opcode decode; illegal encodings collapse to a zeroed operation with illegal set
  always_comb begin
    ctrl_d           = '0;
    ctrl_d.rd        = rd_s;
    ctrl_d.br_funct3 = funct3_s;
    legal_s          = 1'b1;
    writes_s         = 1'b0;

    case (opcode_s)
      OPC_OP: begin
        ctrl_d.opsel = funct3_s;
        ctrl_d.op1   = bus.i_rs1_data;
        ctrl_d.op2   = bus.i_rs2_data;
        ctrl_d.uns   = (funct3_s == 3'b011);
        writes_s     = 1'b1;
        if (funct7_s == F7_BASE) begin
          legal_s = 1'b1;
        end else if ((funct7_s == F7_ALT) && ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
          ctrl_d.sub   = (funct3_s == 3'b000);
          ctrl_d.arith = (funct3_s == 3'b101);
        end else begin
          legal_s = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        ctrl_d.opsel = funct3_s;
        ctrl_d.op1   = bus.i_rs1_data;
        ctrl_d.op2   = imm_i_s;
        ctrl_d.uns   = (funct3_s == 3'b011);
        writes_s     = 1'b1;
        if (funct3_s == 3'b001) begin
          legal_s = (funct7_s == F7_BASE);
        end else if (funct3_s == 3'b101) begin
          legal_s      = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
          ctrl_d.arith = bus.i_inst[30];
        end else begin
          legal_s = 1'b1;
        end
      end
      OPC_LUI: begin
        ctrl_d.op2 = imm_u_s;
        writes_s   = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_d.op1 = bus.i_pc;
        ctrl_d.op2 = imm_u_s;
        writes_s   = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU computes pc + 4, which is the link address written to rd.
        ctrl_d.op1  = bus.i_pc;
        ctrl_d.op2  = 32'd4;
        ctrl_d.jump = 1'b1;
        writes_s    = 1'b1;
        legal_s     = (opcode_s == OPC_JAL) || (funct3_s == 3'b000);
      end
      OPC_BRANCH: begin
        ctrl_d.opsel  = 3'b010;
        ctrl_d.op1    = bus.i_rs1_data;
        ctrl_d.op2    = bus.i_rs2_data;
        ctrl_d.uns    = funct3_s[1];
        ctrl_d.branch = 1'b1;
        legal_s       = (funct3_s != 3'b010) && (funct3_s != 3'b011);
      end
      OPC_LOAD: begin
        ctrl_d.op1  = bus.i_rs1_data;
        ctrl_d.op2  = imm_i_s;
        ctrl_d.load = 1'b1;
        writes_s    = 1'b1;
        case (funct3_s)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
          default:                                legal_s = 1'b0;
        endcase
      end
      OPC_STORE: begin
        ctrl_d.op1   = bus.i_rs1_data;
        ctrl_d.op2   = imm_s_s;
        ctrl_d.store = 1'b1;
        legal_s      = (funct3_s == 3'b000) || (funct3_s == 3'b001) || (funct3_s == 3'b010);
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase

    if (!legal_s) begin
      ctrl_d           = '0;
      ctrl_d.rd        = rd_s;
      ctrl_d.br_funct3 = funct3_s;
      ctrl_d.illegal   = 1'b1;
    end else begin
      ctrl_d.rd_wen = writes_s && (!ZERO_RD_WEN || (rd_s != 5'd0));
    end
  end

  assign in_ready_s = (state_q == ST_EMPTY) || bus.i_out_ready;
  assign accept_s   = bus.i_valid && in_ready_s && !bus.i_flush;

  // Slot occupancy: flush empties, accept fills, drain without accept empties
  always_comb begin
    state_d = state_q;
    if (bus.i_flush) begin
      state_d = ST_EMPTY;
    end else if (accept_s) begin
      state_d = ST_FULL;
    end else if (bus.i_out_ready) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // Occupancy state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers load only on accept so a stalled operation stays bit-stable
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctrl_q <= '0;
      rs2_q  <= 32'h0000_0000;
    end else if (accept_s) begin
      ctrl_q <= ctrl_d;
      rs2_q  <= bus.i_rs2_data;
    end else begin
      ctrl_q <= ctrl_q;
      rs2_q  <= rs2_q;
    end
  end

  assign bus.o_in_ready  = in_ready_s;
  assign bus.o_valid     = (state_q == ST_FULL);
  assign bus.o_opsel     = ctrl_q.opsel;
  assign bus.o_sub       = ctrl_q.sub;
  assign bus.o_unsigned  = ctrl_q.uns;
  assign bus.o_arith     = ctrl_q.arith;
  assign bus.o_op1       = ctrl_q.op1;
  assign bus.o_op2       = ctrl_q.op2;
  assign bus.o_rs2_data  = rs2_q;
  assign bus.o_branch    = ctrl_q.branch;
  assign bus.o_br_funct3 = ctrl_q.br_funct3;
  assign bus.o_jump      = ctrl_q.jump;
  assign bus.o_load      = ctrl_q.load;
  assign bus.o_store     = ctrl_q.store;
  assign bus.o_rd        = ctrl_q.rd;
  assign bus.o_rd_wen    = ctrl_q.rd_wen;
  assign bus.o_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, handshake corner
// sequences, and randomized traffic against a rule-level reference model.
module tb_alu_issue;

  typedef struct packed {
    logic [2:0]  opsel;
    logic        sub;
    logic        uns;
    logic        arith;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        branch;
    logic [2:0]  bf3;
    logic        jump;
    logic        load;
    logic        store;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        illegal;
  } dec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    dec_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if bus ();
  alu_issue #(.ZERO_RD_WEN(1'b1)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  dec_t act;
  assign act = {bus.o_opsel, bus.o_sub, bus.o_unsigned, bus.o_arith, bus.o_op1, bus.o_op2,
                bus.o_branch, bus.o_br_funct3, bus.o_jump, bus.o_load, bus.o_store,
                bus.o_rd, bus.o_rd_wen, bus.o_illegal};

  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_valid  = 1'b0;
  dec_t m_out;
  logic [31:0] m_rs2;

  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  function automatic dec_t mk(input logic [2:0] opsel, input logic sub, input logic uns,
                              input logic arith, input logic [31:0] op1, input logic [31:0] op2,
                              input logic br, input logic [2:0] bf3, input logic j,
                              input logic l, input logic s, input logic [4:0] rd,
                              input logic wen, input logic ill);
    mk = {opsel, sub, uns, arith, op1, op2, br, bf3, j, l, s, rd, wen, ill};
  endfunction

  // Rule-level reference decode of one instruction
  function automatic dec_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2);
    dec_t d;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_u;
    logic ok, writes;
    d      = '0;
    f3     = inst[14:12];
    f7     = inst[31:25];
    imm_i  = $signed(inst) >>> 20;
    imm_s  = {imm_i[31:5], inst[11:7]};
    imm_u  = inst & 32'hFFFF_F000;
    ok     = 1'b1;
    writes = 1'b0;
    case (inst[6:0])
      7'b0110011: begin
        d.opsel = f3; d.op1 = rs1; d.op2 = rs2; writes = 1'b1;
        d.uns   = (f3 == 3'd3);
        d.sub   = (f7 == 7'h20) && (f3 == 3'd0);
        d.arith = (f7 == 7'h20) && (f3 == 3'd5);
        ok      = (f7 == 7'h00) || d.sub || d.arith;
      end
      7'b0010011: begin
        d.opsel = f3; d.op1 = rs1; d.op2 = imm_i; writes = 1'b1;
        d.uns   = (f3 == 3'd3);
        d.arith = (f3 == 3'd5) && inst[30];
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        else ok = 1'b1;
      end
      7'b0110111: begin d.op2 = imm_u; writes = 1'b1; end
      7'b0010111: begin d.op1 = pc; d.op2 = imm_u; writes = 1'b1; end
      7'b1101111: begin d.op1 = pc; d.op2 = 32'd4; d.jump = 1'b1; writes = 1'b1; end
      7'b1100111: begin d.op1 = pc; d.op2 = 32'd4; d.jump = 1'b1; writes = 1'b1; ok = (f3 == 3'd0); end
      7'b1100011: begin
        d.opsel = 3'd2; d.op1 = rs1; d.op2 = rs2; d.uns = f3[1]; d.branch = 1'b1;
        ok = !(f3 inside {3'd2, 3'd3});
      end
      7'b0000011: begin
        d.op1 = rs1; d.op2 = imm_i; d.load = 1'b1; writes = 1'b1;
        ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      7'b0100011: begin d.op1 = rs1; d.op2 = imm_s; d.store = 1'b1; ok = (f3 <= 3'd2); end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d = '0;
      d.illegal = 1'b1;
    end else begin
      d.rd_wen = writes && (inst[11:7] != 5'd0);
    end
    d.rd  = inst[11:7];
    d.bf3 = f3;
    return d;
  endfunction

  task automatic check_model();
    chk("o_valid", {127'd0, bus.o_valid}, {127'd0, m_valid});
    if (m_valid) begin
      chk("decode", {44'd0, act}, {44'd0, m_out});
      chk("rs2_data", {96'd0, bus.o_rs2_data}, {96'd0, m_rs2});
    end
  endtask

  // Drive one cycle of inputs just after a negedge, advance the model, check at next negedge
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic fl, input logic ordy);
    logic rdy, acc;
    bus.i_valid = v; bus.i_inst = inst; bus.i_pc = pc; bus.i_rs1_data = rs1;
    bus.i_rs2_data = rs2; bus.i_flush = fl; bus.i_out_ready = ordy;
    #1;
    rdy = !m_valid || ordy;
    chk("in_ready", {127'd0, bus.o_in_ready}, {127'd0, rdy});
    acc = v && rdy && !fl;
    if (fl) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_out   = ref_decode(inst, pc, rs1, rs2);
      m_rs2   = rs2;
    end else if (ordy) m_valid = 1'b0;
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_out_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", {127'd0, bus.o_valid}, 128'd0);
    chk("rst_data", {44'd0, act}, 128'd0);
    chk("rst_rs2", {96'd0, bus.o_rs2_data}, 128'd0);
    rst = 1'b0;
    m_valid = 1'b0;
  endtask

  localparam logic [31:0] ADD_X3 = 32'h0020_81B3;
  localparam logic [31:0] XOR_X4 = 32'h0020_C233;

  vec_t tv[15];
  logic [6:0] opcs[9];

  initial begin
    dec_t add_exp;
    bus.i_valid = 1'b0; bus.i_inst = 32'd0; bus.i_pc = 32'd0; bus.i_rs1_data = 32'd0;
    bus.i_rs2_data = 32'd0; bus.i_flush = 1'b0; bus.i_out_ready = 1'b0;

    tv[0]  = '{32'h402081B3, 32'h0, 32'd10, 32'd3,
               mk(3'd0, 1'b1, 1'b0, 1'b0, 32'd10, 32'd3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0)};
    tv[1]  = '{32'h40435293, 32'h0, 32'h8000_0000, 32'd0,
               mk(3'd5, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h404, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0)};
    tv[2]  = '{32'h0020E463, 32'h100, 32'd5, 32'd7,
               mk(3'd2, 1'b0, 1'b1, 1'b0, 32'd5, 32'd7, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0)};
    tv[3]  = '{32'hFFFFFFFF, 32'h200, 32'd1, 32'd2,
               mk(3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1)};
    tv[4]  = '{32'h00100013, 32'h0, 32'd0, 32'd0,
               mk(3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0)};
    tv[5]  = '{32'h123453B7, 32'h0, 32'd99, 32'd0,
               mk(3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h1234_5000, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0)};
    tv[6]  = '{32'hFFFFF097, 32'h1000, 32'd0, 32'd0,
               mk(3'd0, 1'b0, 1'b0, 1'b0, 32'h1000, 32'hFFFF_F000, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0)};
    tv[7]  = '{32'h008000EF, 32'h2000, 32'd0, 32'd0,
               mk(3'd0, 1'b0, 1'b0, 1'b0, 32'h2000, 32'd4, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0)};
    tv[8]  = '{32'h000290E7, 32'h3000, 32'd0, 32'd0,
               mk(3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1)};
    tv[9]  = '{32'hFFC12203, 32'h0, 32'h1000, 32'd0,
               mk(3'd0, 1'b0, 1'b0, 1'b0, 32'h1000, 32'hFFFF_FFFC, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0)};
    tv[10] = '{32'h00312423, 32'h0, 32'h3000, 32'hDEAD_BEEF,
               mk(3'd0, 1'b0, 1'b0, 1'b0, 32'h3000, 32'd8, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0)};
    tv[11] = '{32'hFFF4B493, 32'h0, 32'd7, 32'd0,
               mk(3'd3, 1'b0, 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFF, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0)};
    tv[12] = '{32'h02009093, 32'h0, 32'd1, 32'd0,
               mk(3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1)};
    tv[13] = '{32'h402091B3, 32'h0, 32'd1, 32'd2,
               mk(3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1)};
    tv[14] = '{32'h0020A463, 32'h0, 32'd1, 32'd2,
               mk(3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1)};
    add_exp = mk(3'd0, 1'b0, 1'b0, 1'b0, 32'd20, 32'd22, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
             7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011};

    // Reset state, including the combinational ready with an empty slot
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {127'd0, bus.o_valid}, 128'd0);
    chk("rst_data", {44'd0, act}, 128'd0);
    chk("rst_in_ready", {127'd0, bus.o_in_ready}, 128'd1);
    rst = 1'b0;

    // Directed vector table, one instruction per cycle with the sink always ready
    for (int i = 0; i < 15; i++) begin
      bus.i_valid = 1'b1; bus.i_inst = tv[i].inst; bus.i_pc = tv[i].pc;
      bus.i_rs1_data = tv[i].rs1; bus.i_rs2_data = tv[i].rs2;
      bus.i_flush = 1'b0; bus.i_out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {127'd0, bus.o_valid}, 128'd1);
      chk($sformatf("vec%0d_decode", i), {44'd0, act}, {44'd0, tv[i].exp});
      chk($sformatf("vec%0d_rs2", i), {96'd0, bus.o_rs2_data}, {96'd0, tv[i].rs2});
    end

    // Backpressure: held ADD stays frozen, then XOR follows with no bubble
    do_reset();
    step(1'b1, ADD_X3, 32'd0, 32'd20, 32'd22, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, XOR_X4, 32'd0, 32'd6, 32'd3, 1'b0, 1'b0);
      chk("stall_in_ready", {127'd0, bus.o_in_ready}, 128'd0);
      chk("stall_hold", {44'd0, act}, {44'd0, add_exp});
    end
    step(1'b1, XOR_X4, 32'd0, 32'd6, 32'd3, 1'b0, 1'b1);
    chk("nobubble_valid", {127'd0, bus.o_valid}, 128'd1);
    chk("nobubble_opsel", {125'd0, bus.o_opsel}, 128'd4);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("drain_valid", {127'd0, bus.o_valid}, 128'd0);

    // Flush kills both the held operation and the offered one
    step(1'b1, ADD_X3, 32'd0, 32'd20, 32'd22, 1'b0, 1'b0);
    step(1'b1, XOR_X4, 32'd0, 32'd6, 32'd3, 1'b1, 1'b0);
    chk("flush_valid", {127'd0, bus.o_valid}, 128'd0);
    step(1'b0, XOR_X4, 32'd0, 32'd6, 32'd3, 1'b0, 1'b1);
    step(1'b0, XOR_X4, 32'd0, 32'd6, 32'd3, 1'b0, 1'b1);
    chk("flushed_never_issues", {127'd0, bus.o_valid}, 128'd0);

    // Reset mid-stall clears outputs without waiting for a clock edge
    step(1'b1, ADD_X3, 32'd0, 32'd20, 32'd22, 1'b0, 1'b0);
    step(1'b1, XOR_X4, 32'd0, 32'd6, 32'd3, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {127'd0, bus.o_valid}, 128'd0);
    chk("async_rst_data", {44'd0, act}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0;
    step(1'b1, XOR_X4, 32'd0, 32'd6, 32'd3, 1'b0, 1'b1);
    chk("accept_after_rst", {127'd0, bus.o_valid}, 128'd1);

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r, inst;
      int kind;
      r    = $urandom;
      kind = $urandom_range(0, 10);
      if (kind < 9) inst = {r[31:7], opcs[kind]};
      else inst = $urandom;
      if ($urandom_range(0, 1) == 1) inst[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 7) == 0) inst[11:7] = 5'd0;
      step($urandom_range(0, 9) < 7, inst, $urandom, $urandom, $urandom,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
